calc_uart_cmd_rx: RTL and testbench
===================================

CALC_UART_CMD_RX -- requirements
Module: calc_uart_cmd_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16, meaning clk cycles per UART bit period (legal range 4..65535).
REQ-002 SHALL provide port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL provide port ena, input, 1, block enable; low forces the idle state.
REQ-005 SHALL provide port rx, input, 1, asynchronous UART serial line, 8N1, LSB first, idle high.
REQ-006 SHALL provide port operand, output, 8, operand byte for the calculator (drives ui_in).
REQ-007 SHALL provide port opcode, output, 4, opcode for the calculator (drives uio_in[4:1]).
REQ-008 SHALL provide port enter, output, 1, one-cycle command strobe (drives uio_in[0]).
REQ-009 SHALL provide port busy, output, 1, high while a byte or a multi-byte command is in progress.
REQ-010 SHALL provide port frame_err, output, 1, one-cycle pulse when a stop bit samples 0.
REQ-011 SHALL provide port hdr_err, output, 1, one-cycle pulse when a header byte has a bad sync nibble.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1) before any use.
REQ-013 SHALL run a byte FSM with states IDLE, START, DATA, STOP.
REQ-014 SHALL leave IDLE for START on a synchronized falling edge of rx.
REQ-015 SHALL resample rx at CLKS_PER_BIT/2 in START: low -> DATA, high -> IDLE (glitch), with no error and no byte.
REQ-016 SHALL sample 8 data bits at CLKS_PER_BIT intervals from the start-bit mid-point, LSB first.
REQ-017 SHALL sample the stop bit one further CLKS_PER_BIT after the last data bit, then return to IDLE.
REQ-018 SHALL treat a stop bit of 1 as a valid byte; 0 SHALL pulse frame_err, discard the byte and reset the command FSM to WAIT_HDR.
REQ-019 SHALL run a command FSM with states WAIT_HDR, WAIT_OPND, ISSUE.
REQ-020 SHALL treat the first byte as the header: bits[7:4] are sync and must equal 0xA; bits[3:0] are the opcode.
REQ-021 SHALL pulse hdr_err on a bad sync nibble, drop the byte and stay in WAIT_HDR.
REQ-022 SHALL define binary opcodes 0x0-0x4 and 0xD-0xF: WAIT_HDR -> WAIT_OPND, and the next valid byte becomes the operand.
REQ-023 SHALL define unary opcodes 0x5-0xC: WAIT_HDR -> ISSUE directly, with operand keeping its previous value.
REQ-024 SHALL stage the new opcode/operand internally and update the opcode and operand outputs only in the ISSUE cycle.
REQ-025 SHALL assert enter high for exactly one cycle: the cycle after the final byte's stop-bit sample cycle.
REQ-026 SHALL hold opcode and operand stable from the enter cycle until the next enter.
REQ-027 SHALL return from ISSUE to WAIT_HDR unconditionally after one cycle.
REQ-028 SHALL drive busy = (byte FSM != IDLE) OR (command FSM != WAIT_HDR).
REQ-029 SHALL, while ena=0, hold both FSMs in IDLE/WAIT_HDR, force enter/frame_err/hdr_err low, and retain opcode/operand.
REQ-030 SHALL size the bit-period counter to ceil(log2(CLKS_PER_BIT))+1 bits and reload it without drift on every bit.

Reset
REQ-031 SHALL, on rst_n low, immediately force operand=0x00, opcode=0x0, enter=0, busy=0, frame_err=0, hdr_err=0, synchronizer=1, byte FSM=IDLE, command FSM=WAIT_HDR.
REQ-032 SHALL abandon any partial byte or command when reset is asserted mid-frame and start no frame until a new falling edge after release.

Verification (CLKS_PER_BIT=16)
REQ-033 SHALL check reset: after rst_n low then high with rx=1, all outputs are 0 and stay 0 for 200 cycles.
REQ-034 SHALL check a binary command: send 0xA0 then 0x01 -> exactly one enter pulse, with opcode=0x0 and operand=0x01 in the enter cycle, and busy low afterwards.
REQ-035 SHALL check a unary command: after REQ-034, send 0xA5 -> one enter pulse after the single byte, opcode=0x5, operand still 0x01.
REQ-036 SHALL check the error paths: header 0x30 -> one hdr_err pulse and no enter; then send 0xAE and operand 0x7F with stop=0 -> one frame_err pulse and no enter; then send 0xAF, 0x00 -> enter with opcode=0xF, operand=0x00.
REQ-037 SHALL check a glitch: rx low for 4 cycles -> no byte, no error, busy returns low within CLKS_PER_BIT/2+3 cycles.
REQ-038 SHALL check reset mid-frame: assert rst_n low during the operand data bits -> no enter, outputs return to reset values, and the next full frame 0xA1, 0x0F -> enter with opcode=0x1, operand=0x0F.

Source files
------------

// File: rtl/calc_uart_cmd_rx.sv
// calc_uart_cmd_rx
//   UART (8N1, LSB first) command receiver for the calculator core.
//   A command is a header byte {sync=4'hA, opcode} optionally followed by an
//   operand byte. The opcode class decides whether an operand byte follows.
//   Once the command is complete, the staged opcode/operand are presented
//   together with a one-cycle enter strobe.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   ena        : block enable; low holds both FSMs idle and masks strobes
//   rx         : asynchronous serial input, idle high
//   operand    : operand byte presented to the calculator
//   opcode     : 4-bit opcode presented to the calculator
//   enter      : one-cycle command strobe
//   busy       : byte reception or multi-byte command in progress
//   frame_err  : one-cycle pulse, stop bit sampled low
//   hdr_err    : one-cycle pulse, header sync nibble not 4'hA
module calc_uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] operand,
  output logic [3:0] opcode,
  output logic       enter,
  output logic       busy,
  output logic       frame_err,
  output logic       hdr_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;
  typedef enum logic [1:0] {C_WAIT_HDR, C_WAIT_OPND, C_ISSUE} cmd_state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer and falling-edge detect
  // ---------------------------------------------------------------------------
  logic       rx_s1_q, rx_s2_q, rx_prev_q, rx_prev_d;
  logic [1:0] sync_vld_q, sync_vld_d;
  logic       rx_fall;

  // sync_vld_q marks when rx_s2_q carries a real sample rather than its reset
  // value. Until then rx_prev is held at 0 so a line that is already low when
  // reset is released is not mistaken for a start-bit edge.
  always_comb begin
    sync_vld_d = {sync_vld_q[0], 1'b1};
    rx_prev_d  = rx_s2_q & sync_vld_q[1];
    rx_fall    = rx_prev_q & ~rx_s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b0;
      sync_vld_q <= 2'b00;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_prev_d;
      sync_vld_q <= sync_vld_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FSM
  // ---------------------------------------------------------------------------
  byte_state_e   byte_q, byte_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          byte_done;   // stop-bit sample cycle
  logic          byte_ok;     // stop bit was 1

  always_comb begin
    byte_d    = byte_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    byte_ok   = 1'b0;
    case (byte_q)
      B_IDLE: begin
        cnt_d = '0;
        if (rx_fall) byte_d = B_START;
      end
      B_START: begin
        if (cnt_q == HALF_MAX) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          byte_d    = rx_s2_q ? B_IDLE : B_DATA;  // high at mid-start = glitch
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_DATA: begin
        if (cnt_q == BIT_MAX) begin
          // Counter restarts from zero on each sample, so sample points stay
          // exactly one bit period apart with no accumulated drift.
          cnt_d     = '0;
          shreg_d   = {rx_s2_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) byte_d = B_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_STOP: begin
        if (cnt_q == BIT_MAX) begin
          cnt_d     = '0;
          byte_done = 1'b1;
          byte_ok   = rx_s2_q;
          byte_d    = B_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: byte_d = B_IDLE;
    endcase
    if (!ena) begin
      byte_d    = B_IDLE;
      cnt_d     = '0;
      byte_done = 1'b0;
      byte_ok   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q    <= B_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
    end else begin
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  cmd_state_e cmd_q, cmd_d;
  logic [3:0] op_stage_q, op_stage_d;
  logic [3:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic       frame_err_q, frame_err_d;
  logic       hdr_err_q, hdr_err_d;
  logic       hdr_binary;

  // Opcodes 0x0-0x4 and 0xD-0xF take an operand byte; 0x5-0xC are unary.
  assign hdr_binary = (shreg_q[3:0] <= 4'h4) || (shreg_q[3:0] >= 4'hD);

  always_comb begin
    cmd_d       = cmd_q;
    op_stage_d  = op_stage_q;
    opcode_d    = opcode_q;
    operand_d   = operand_q;
    frame_err_d = 1'b0;
    hdr_err_d   = 1'b0;
    if (byte_done && !byte_ok) begin
      frame_err_d = 1'b1;
      cmd_d       = C_WAIT_HDR;
    end else begin
      case (cmd_q)
        C_WAIT_HDR: begin
          if (byte_done) begin
            if (shreg_q[7:4] != 4'hA) begin
              hdr_err_d = 1'b1;
            end else if (hdr_binary) begin
              op_stage_d = shreg_q[3:0];
              cmd_d      = C_WAIT_OPND;
            end else begin
              // Unary: operand output keeps its previous value.
              opcode_d = shreg_q[3:0];
              cmd_d    = C_ISSUE;
            end
          end
        end
        C_WAIT_OPND: begin
          if (byte_done) begin
            opcode_d  = op_stage_q;
            operand_d = shreg_q;
            cmd_d     = C_ISSUE;
          end
        end
        C_ISSUE: cmd_d = C_WAIT_HDR;
        default: cmd_d = C_WAIT_HDR;
      endcase
    end
    if (!ena) begin
      cmd_d       = C_WAIT_HDR;
      opcode_d    = opcode_q;
      operand_d   = operand_q;
      frame_err_d = 1'b0;
      hdr_err_d   = 1'b0;
    end
  end

  // Outputs load on the edge that enters ISSUE so the new values are already
  // visible during the enter cycle and stay put until the next command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= C_WAIT_HDR;
      op_stage_q  <= 4'h0;
      opcode_q    <= 4'h0;
      operand_q   <= 8'h00;
      frame_err_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      op_stage_q  <= op_stage_d;
      opcode_q    <= opcode_d;
      operand_q   <= operand_d;
      frame_err_q <= frame_err_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

  assign operand   = operand_q;
  assign opcode    = opcode_q;
  assign enter     = (cmd_q == C_ISSUE) && ena;
  assign busy      = (byte_q != B_IDLE) || (cmd_q != C_WAIT_HDR);
  assign frame_err = frame_err_q & ena;
  assign hdr_err   = hdr_err_q & ena;

endmodule

// File: tb/tb_calc_uart_cmd_rx.sv
module tb_calc_uart_cmd_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, rx = 1'b1;
  logic [7:0] operand;
  logic [3:0] opcode;
  logic       enter, busy, frame_err, hdr_err;

  calc_uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx),
    .operand(operand), .opcode(opcode), .enter(enter), .busy(busy),
    .frame_err(frame_err), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  // ---- output monitor (sampled on the falling edge) ----
  int         n_enter = 0, n_ferr = 0, n_herr = 0, stab_err = 0, wide_err = 0;
  int         enter_cyc = 0;
  logic [3:0] obs_op[$];
  logic [7:0] obs_opnd[$];
  logic       prev_enter = 1'b0;
  logic [3:0] last_op = 4'h0;
  logic [7:0] last_opnd = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (enter) begin
        n_enter++;
        obs_op.push_back(opcode);
        obs_opnd.push_back(operand);
        enter_cyc = cyc;
        if (prev_enter) wide_err++;
      end else if (opcode !== last_op || operand !== last_opnd) begin
        stab_err++;
      end
      if (frame_err) n_ferr++;
      if (hdr_err)   n_herr++;
    end
    prev_enter = enter;
    last_op    = opcode;
    last_opnd  = operand;
  end

  // ---- reference model: command-level behaviour from the byte stream ----
  logic       m_pend = 1'b0;
  logic [3:0] m_pop  = 4'h0;
  logic [7:0] m_opnd = 8'h00;
  logic [3:0] exp_op[$];
  logic [7:0] exp_opnd[$];
  int         exp_ferr = 0, exp_herr = 0;

  task automatic model_byte(input logic [7:0] b, input logic stop);
    if (!stop) begin
      exp_ferr++;
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_opnd = b;
      exp_op.push_back(m_pop);
      exp_opnd.push_back(b);
      m_pend = 1'b0;
    end else if (b[7:4] != 4'hA) begin
      exp_herr++;
    end else if (b[3:0] <= 4'h4 || b[3:0] >= 4'hD) begin
      m_pend = 1'b1;
      m_pop  = b[3:0];
    end else begin
      exp_op.push_back(b[3:0]);
      exp_opnd.push_back(m_opnd);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int last_start_cyc = 0;

  // Sends one full frame plus one idle bit period; the model sees it if track.
  task automatic send_byte(input logic [7:0] b, input logic stop, input logic track);
    @(posedge clk); #1;
    last_start_cyc = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    if (track) model_byte(b, stop);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic bad;
    rst_n = 1'b0; rx = 1'b1; ena = 1'b1;
    #23;
    n_checks++;
    if ({operand, opcode, enter, busy, frame_err, hdr_err} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_values: got op=%h opnd=%h en=%b busy=%b fe=%b he=%b want all 0",
               opcode, operand, enter, busy, frame_err, hdr_err);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if ({operand, opcode, enter, busy, frame_err, hdr_err} !== 16'h0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_hold_200: got nonzero output want all 0 for 200 cycles");
    end
  endtask

  task automatic test_binary();
    int e0;
    e0 = n_enter;
    send_byte(8'hA0, 1'b1, 1'b1);
    send_byte(8'h01, 1'b1, 1'b1);
    n_checks++;
    if (n_enter - e0 != 1) begin
      n_fail++;
      $display("FAIL binary_enter_count: got %0d want 1", n_enter - e0);
    end
    n_checks++;
    if (obs_op.size() != 0 && (obs_op[$] !== 4'h0 || obs_opnd[$] !== 8'h01)) begin
      n_fail++;
      $display("FAIL binary_values: got op=%h opnd=%h want op=0 opnd=01", obs_op[$], obs_opnd[$]);
    end
    // Enter falls in the cycle after the mid-stop-bit sample of the last byte.
    n_checks++;
    if (enter_cyc < last_start_cyc + 151 || enter_cyc > last_start_cyc + 159) begin
      n_fail++;
      $display("FAIL binary_enter_time: got offset %0d want 151..159", enter_cyc - last_start_cyc);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL binary_busy_after: got %b want 0", busy);
    end
  endtask

  task automatic test_unary();
    int e0;
    e0 = n_enter;
    send_byte(8'hA5, 1'b1, 1'b1);
    n_checks++;
    if (n_enter - e0 != 1) begin
      n_fail++;
      $display("FAIL unary_enter_count: got %0d want 1", n_enter - e0);
    end
    n_checks++;
    if (obs_op.size() != 0 && (obs_op[$] !== 4'h5 || obs_opnd[$] !== 8'h01)) begin
      n_fail++;
      $display("FAIL unary_values: got op=%h opnd=%h want op=5 opnd=01", obs_op[$], obs_opnd[$]);
    end
  endtask

  task automatic test_errors();
    int e0, h0, f0;
    e0 = n_enter; h0 = n_herr; f0 = n_ferr;
    send_byte(8'h30, 1'b1, 1'b1);
    n_checks++;
    if (n_herr - h0 != 1 || n_enter != e0) begin
      n_fail++;
      $display("FAIL hdr_err_path: got herr=%0d enter=%0d want herr=1 enter=0", n_herr - h0, n_enter - e0);
    end
    send_byte(8'hAE, 1'b1, 1'b1);
    send_byte(8'h7F, 1'b0, 1'b1);
    n_checks++;
    if (n_ferr - f0 != 1 || n_enter != e0) begin
      n_fail++;
      $display("FAIL frame_err_path: got ferr=%0d enter=%0d want ferr=1 enter=0", n_ferr - f0, n_enter - e0);
    end
    send_byte(8'hAF, 1'b1, 1'b1);
    send_byte(8'h00, 1'b1, 1'b1);
    n_checks++;
    if (n_enter - e0 != 1 || obs_op[$] !== 4'hF || obs_opnd[$] !== 8'h00) begin
      n_fail++;
      $display("FAIL recover_after_err: got n=%0d op=%h opnd=%h want n=1 op=F opnd=00",
               n_enter - e0, opcode, operand);
    end
  endtask

  task automatic test_glitch();
    int e0, h0, f0, waited;
    logic seen_busy;
    e0 = n_enter; h0 = n_herr; f0 = n_ferr;
    tick(4);
    rx = 1'b0;
    tick(4);
    seen_busy = busy;
    rx = 1'b1;
    waited = 0;
    while (busy !== 1'b0 && waited < CPB / 2 + 3) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (seen_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_seen: got %b want 1", seen_busy);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy_timeout: got busy=%b after %0d cycles want 0", busy, waited);
    end
    tick(2 * CPB);
    n_checks++;
    if (n_enter != e0 || n_herr != h0 || n_ferr != f0) begin
      n_fail++;
      $display("FAIL glitch_events: got enter=%0d herr=%0d ferr=%0d want 0 0 0",
               n_enter - e0, n_herr - h0, n_ferr - f0);
    end
  endtask

  task automatic test_midframe_reset();
    int e0;
    e0 = n_enter;
    send_byte(8'hA3, 1'b1, 1'b1);
    @(posedge clk); #1;
    rx = 1'b0;                 // operand 0x00 start bit
    tick(CPB + 3 * CPB + 5);   // part-way into the data bits
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    n_checks++;
    if ({operand, opcode, enter, busy, frame_err, hdr_err} !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset_values: got op=%h opnd=%h en=%b busy=%b want all 0",
               opcode, operand, enter, busy);
    end
    m_pend = 1'b0; m_pop = 4'h0; m_opnd = 8'h00;
    tick(5);
    rst_n = 1'b1;
    tick(3 * CPB);
    n_checks++;
    if (n_enter != e0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_enter: got enter=%0d busy=%b want 0 0", n_enter - e0, busy);
    end
    send_byte(8'hA1, 1'b1, 1'b1);
    send_byte(8'h0F, 1'b1, 1'b1);
    n_checks++;
    if (n_enter - e0 != 1 || obs_op[$] !== 4'h1 || obs_opnd[$] !== 8'h0F) begin
      n_fail++;
      $display("FAIL midreset_next_cmd: got n=%0d op=%h opnd=%h want n=1 op=1 opnd=0F",
               n_enter - e0, opcode, operand);
    end
  endtask

  task automatic test_enable();
    int e0;
    e0 = n_enter;
    ena = 1'b0;
    send_byte(8'hA6, 1'b1, 1'b0);
    n_checks++;
    if (n_enter != e0 || busy !== 1'b0 || opcode !== 4'h1 || operand !== 8'h0F) begin
      n_fail++;
      $display("FAIL ena_low_ignored: got enter=%0d busy=%b op=%h opnd=%h want 0 0 1 0F",
               n_enter - e0, busy, opcode, operand);
    end
    ena = 1'b1;
    send_byte(8'hA2, 1'b1, 1'b1);   // binary header, then drop ena to abort it
    ena = 1'b0;
    tick(3);
    ena = 1'b1;
    m_pend = 1'b0;
    send_byte(8'hA7, 1'b1, 1'b1);
    n_checks++;
    if (n_enter - e0 != 1 || obs_op[$] !== 4'h7 || obs_opnd[$] !== 8'h0F) begin
      n_fail++;
      $display("FAIL ena_abort_cmd: got n=%0d op=%h opnd=%h want n=1 op=7 opnd=0F",
               n_enter - e0, opcode, operand);
    end
  endtask

  task automatic test_random();
    int h0, f0, eh0, ef0, r;
    logic [7:0] hdr, opnd;
    obs_op.delete(); obs_opnd.delete();
    exp_op.delete(); exp_opnd.delete();
    h0 = n_herr; f0 = n_ferr; eh0 = exp_herr; ef0 = exp_ferr;
    for (int it = 0; it < 24; it++) begin
      r    = $urandom_range(0, 9);
      hdr  = 8'($urandom_range(0, 255));
      opnd = 8'($urandom_range(0, 255));
      if (r == 0) begin
        if (hdr[7:4] == 4'hA) hdr[7:4] = 4'h5;
        send_byte(hdr, 1'b1, 1'b1);
      end else if (r == 1) begin
        send_byte({4'hA, 4'h2}, 1'b1, 1'b1);
        send_byte(opnd, 1'b0, 1'b1);
      end else begin
        hdr[7:4] = 4'hA;
        send_byte(hdr, 1'b1, 1'b1);
        if (hdr[3:0] <= 4'h4 || hdr[3:0] >= 4'hD) send_byte(opnd, 1'b1, 1'b1);
      end
    end
    n_checks++;
    if (obs_op.size() != exp_op.size()) begin
      n_fail++;
      $display("FAIL rand_enter_count: got %0d want %0d", obs_op.size(), exp_op.size());
    end
    while (obs_op.size() > 0 && exp_op.size() > 0) begin
      logic [3:0] go, eo;
      logic [7:0] gd, ed;
      go = obs_op.pop_front();  gd = obs_opnd.pop_front();
      eo = exp_op.pop_front();  ed = exp_opnd.pop_front();
      n_checks++;
      if (go !== eo || gd !== ed) begin
        n_fail++;
        $display("FAIL rand_cmd: got op=%h opnd=%h want op=%h opnd=%h", go, gd, eo, ed);
      end
    end
    n_checks++;
    if (n_herr - h0 != exp_herr - eh0 || n_ferr - f0 != exp_ferr - ef0) begin
      n_fail++;
      $display("FAIL rand_err_counts: got herr=%0d ferr=%0d want herr=%0d ferr=%0d",
               n_herr - h0, n_ferr - f0, exp_herr - eh0, exp_ferr - ef0);
    end
  endtask

  task automatic test_hold();
    n_checks++;
    if (stab_err != 0 || wide_err != 0) begin
      n_fail++;
      $display("FAIL hold_and_pulse: got changes=%0d wide_enter=%0d want 0 0", stab_err, wide_err);
    end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_unary();
    test_errors();
    test_glitch();
    test_midframe_reset();
    test_enable();
    test_random();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
